piso_stream: RTL

Parametrised parallel-in/serial-out shifter with valid/ready handshakes on both sides.
- Accepts a WIDTH-bit word, then emits it one bit per accepted serial beat.
- Bit order (MSB-first or LSB-first) is selectable per word.
- Supports back-to-back words with zero bubble cycles and serial-side backpressure.
- Sits between a word-oriented producer and a bit-serial link or serializer front end.

---
 rtl/piso_pkg.sv | 15 +
 rtl/piso_bit_counter.sv | 47 ++++
 rtl/piso_stream.sv | 112 +++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_stream parallel-in/serial-out shifter.
//   state_e : FSM state encoding (IDLE = no word held, SHIFT = word in flight)
//   cnt_w   : bit-counter width needed to index a word of the given width
package piso_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Beat counter for piso_stream: counts accepted serial beats within one word.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset, clears the count
//   clear    : restart at 0 (word load or final beat); wins over inc
//   inc      : advance by one (non-final accepted beat)
//   count    : current beat index, 0..WIDTH-1
//   is_first : count == 0
//   is_last  : count == WIDTH-1
module piso_bit_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = piso_pkg::cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             is_first,
  output logic             is_last
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign is_first = (count_q == '0);
  assign is_last  = (count_q == LastCnt);

endmodule

// File: rtl/piso_stream.sv
// Parallel-in/serial-out shifter with valid/ready on both sides and per-word bit order.
//   clk, rst         : rising-edge clock, synchronous active-high reset
//   in_data          : WIDTH-bit parallel word
//   in_lsb_first     : 1 = emit bit 0 first, 0 = emit bit WIDTH-1 first (sampled on load)
//   in_valid         : producer offers a word
//   in_ready         : word is loaded this cycle (combinational)
//   ser_out          : current serial bit
//   ser_valid        : ser_out is a valid beat
//   ser_ready        : consumer accepts the beat this cycle
//   ser_first        : beat is the first bit of its word
//   ser_last         : beat is the last bit of its word
//   busy             : a word is in flight (same as ser_valid)
module piso_stream
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter bit          RST_LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_lsb_first,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int unsigned CNT_W = cnt_w(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] sreg_q;
  logic             lsb_q;

  logic [CNT_W-1:0] count;
  logic             is_first;
  logic             is_last;
  logic             shifting;
  logic             beat;
  logic             in_xfer;

  assign shifting = (state_q == SHIFT);
  assign beat     = shifting && ser_ready;
  // A new word can enter on the final beat, giving zero-bubble back-to-back words.
  assign in_ready = !rst && (!shifting || (ser_last && ser_ready));
  assign in_xfer  = in_valid && in_ready;

  piso_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (in_xfer || (beat && is_last)),
    .inc      (beat && !is_last),
    .count    (count),
    .is_first (is_first),
    .is_last  (is_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      lsb_q   <= RST_LSB_FIRST;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_xfer) begin
            sreg_q  <= in_data;
            lsb_q   <= in_lsb_first;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (beat) begin
            if (is_last) begin
              if (in_xfer) begin
                sreg_q <= in_data;
                lsb_q  <= in_lsb_first;
              end else begin
                // Clear so ser_out reads 0 while idle.
                sreg_q  <= '0;
                state_q <= IDLE;
              end
            end else if (lsb_q) begin
              sreg_q <= sreg_q >> 1;
            end else begin
              sreg_q <= sreg_q << 1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ser_out   = lsb_q ? sreg_q[0] : sreg_q[WIDTH-1];
  assign ser_valid = shifting;
  assign busy      = shifting;
  assign ser_first = shifting && is_first;
  assign ser_last  = shifting && is_last;

  // The counter must never run past the last beat, and sits at 0 when idle.
  a_cnt_range : assert property (@(posedge clk) disable iff (rst)
    (count <= CNT_W'(WIDTH - 1)) && (shifting || count == '0));

endmodule
